// File: rtl/xadc_block_averager_if.sv
// Sample/average bus between the XADC wrapper side and the block averager.
interface xadc_block_averager_if #(
    parameter int LOG2_SAMPLES = 8
);
    logic                    enable;
    logic                    clear;
    logic                    raw_valid;
    logic [11:0]             raw_in;
    logic [15:0]             avg_out;
    logic                    avg_valid;
    logic [LOG2_SAMPLES-1:0] window_count;

    modport master (
        output enable, clear, raw_valid, raw_in,
        input  avg_out, avg_valid, window_count
    );

    modport slave (
        input  enable, clear, raw_valid, raw_in,
        output avg_out, avg_valid, window_count
    );
endinterface

// File: rtl/xadc_block_averager.sv
// Sums 2**LOG2_SAMPLES raw 12-bit conversions and publishes the mean in 12.4 format.
module xadc_block_averager #(
    parameter int LOG2_SAMPLES = 8
) (
    input  logic                  clk,
    input  logic                  reset_n,
    xadc_block_averager_if.slave  bus
);
    localparam int AW = 12 + LOG2_SAMPLES;

    typedef enum logic {IDLE, ACCUM} state_t;

    state_t                  state_q, state_d;
    logic [AW-1:0]           acc_q, acc_d, acc_sum;
    logic [LOG2_SAMPLES-1:0] cnt_q, cnt_d;
    logic [15:0]             avg_q, avg_d;
    logic                    vld_q, vld_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            avg_q   <= '0;
            vld_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            avg_q   <= avg_d;
            vld_q   <= vld_d;
        end
    end

    always_comb begin
        acc_sum = acc_q + AW'(bus.raw_in);
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        avg_d   = avg_q;
        vld_d   = 1'b0;
        case (state_q)
            IDLE: begin
                acc_d = '0;
                cnt_d = '0;
                if (bus.enable) state_d = ACCUM;
            end
            ACCUM: begin
                if (!bus.enable) begin
                    state_d = IDLE;
                    acc_d   = '0;
                    cnt_d   = '0;
                end else if (bus.clear) begin
                    acc_d = '0;
                    cnt_d = '0;
                end else if (bus.raw_valid) begin
                    if (&cnt_q) begin
                        // Top 16 bits of the full sum == sum >> (LOG2_SAMPLES-4)
                        avg_d = acc_sum[AW-1 -: 16];
                        vld_d = 1'b1;
                        acc_d = '0;
                        cnt_d = '0;
                    end else begin
                        acc_d = acc_sum;
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.avg_out      = avg_q;
    assign bus.avg_valid    = vld_q;
    assign bus.window_count = cnt_q;
endmodule

// File: tb/tb_xadc_block_averager.sv
// Scoreboard bench for xadc_block_averager with LOG2_SAMPLES=8.
module tb_xadc_block_averager;
    localparam int L  = 8;
    localparam int NS = 1 << L;

    typedef struct {
        logic [15:0] avg;
        int          cyc;
    } exp_t;

    logic clk;
    logic reset_n;
    int   checks = 0;
    int   errors = 0;
    int   cyc_n  = 0;
    exp_t sbq[$];

    // bench model of the window in progress
    int   sum_m   = 0;
    int   cnt_m   = 0;
    logic en_prev = 1'b0;

    xadc_block_averager_if #(.LOG2_SAMPLES(L)) bus ();

    xadc_block_averager #(.LOG2_SAMPLES(L)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc_n++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", tag, got, exp, cyc_n);
        end
    endtask

    // One clock of stimulus; the model tracks what the DUT should accept on the coming edge.
    task automatic cyc(input logic e, input logic v, input logic [11:0] d, input logic c);
        exp_t x;
        @(posedge clk);
        #1;
        chk("wcnt", {24'd0, bus.window_count}, cnt_m);
        bus.enable    = e;
        bus.raw_valid = v;
        bus.raw_in    = d;
        bus.clear     = c;
        if (!e || c) begin
            sum_m = 0;
            cnt_m = 0;
        end else if (v && en_prev) begin
            sum_m += int'(d);
            cnt_m++;
            if (cnt_m == NS) begin
                x.avg = 16'(sum_m >> (L - 4));
                x.cyc = cyc_n + 1;
                sbq.push_back(x);
                sum_m = 0;
                cnt_m = 0;
            end
        end
        en_prev = e;
    endtask

    task automatic run(input int n, input logic [11:0] d);
        for (int i = 0; i < n; i++) cyc(1'b1, 1'b1, d, 1'b0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 12'h0, 1'b0);
    endtask

    // Monitor: every pulse must match the head of the queue at the predicted cycle;
    // between pulses avg_out must not move.
    initial begin
        exp_t        e;
        logic [15:0] last_avg = 16'h0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                last_avg = 16'h0;
            end else if (bus.avg_valid) begin
                if (sbq.size() == 0) begin
                    chk("spurious_pulse", {31'd0, bus.avg_valid}, 32'd0);
                end else begin
                    e = sbq.pop_front();
                    chk("avg", {16'd0, bus.avg_out}, {16'd0, e.avg});
                    chk("latency", cyc_n, e.cyc);
                    last_avg = e.avg;
                end
            end else begin
                chk("hold", {16'd0, bus.avg_out}, {16'd0, last_avg});
            end
        end
    end

    initial begin
        reset_n       = 1'b0;
        bus.enable    = 1'b0;
        bus.clear     = 1'b0;
        bus.raw_valid = 1'b0;
        bus.raw_in    = 12'h0;
        #12;
        chk("rst_avg",  {16'd0, bus.avg_out}, 32'h0);
        chk("rst_vld",  {31'd0, bus.avg_valid}, 32'd0);
        chk("rst_wcnt", {24'd0, bus.window_count}, 32'd0);
        @(posedge clk);
        #3 reset_n = 1'b1;

        // enable first so the IDLE->ACCUM cycle carries no sample
        cyc(1'b1, 1'b0, 12'h0, 1'b0);

        run(NS, 12'h800);
        idle(1);
        chk("t1_avg", {16'd0, bus.avg_out}, 32'h8000);

        run(NS, 12'hFFF);
        idle(1);
        chk("t2_full", {16'd0, bus.avg_out}, 32'hFFF0);
        run(NS, 12'h000);
        idle(1);
        chk("t2_zero", {16'd0, bus.avg_out}, 32'h0000);

        for (int i = 0; i < NS; i++) cyc(1'b1, 1'b1, (i % 2) ? 12'hFFF : 12'h000, 1'b0);
        idle(1);
        chk("t3_alt",  {16'd0, bus.avg_out}, 32'h7FF8);
        chk("t3_wcnt", {24'd0, bus.window_count}, 32'd0);

        run(100, 12'h123);
        cyc(1'b1, 1'b1, 12'h123, 1'b1);
        run(NS, 12'h010);
        idle(1);
        chk("t4_clear", {16'd0, bus.avg_out}, 32'h0100);

        run(200, 12'h3AB);
        for (int i = 0; i < 5; i++) cyc(1'b0, 1'b1, 12'hFFF, 1'b0);
        cyc(1'b1, 1'b0, 12'h0, 1'b0);
        run(NS, 12'h400);
        idle(1);
        chk("t5_dis", {16'd0, bus.avg_out}, 32'h4000);

        // clear on the completing strobe must suppress the pulse
        run(NS - 1, 12'h777);
        cyc(1'b1, 1'b1, 12'h777, 1'b1);
        idle(2);
        chk("clr_cmpl", {16'd0, bus.avg_out}, 32'h4000);

        run(50, 12'h555);
        @(posedge clk);
        #3 reset_n = 1'b0;
        #1;
        chk("mid_rst_avg",  {16'd0, bus.avg_out}, 32'h0);
        chk("mid_rst_vld",  {31'd0, bus.avg_valid}, 32'd0);
        chk("mid_rst_wcnt", {24'd0, bus.window_count}, 32'd0);
        sum_m   = 0;
        cnt_m   = 0;
        en_prev = 1'b0;
        @(posedge clk);
        #3 reset_n = 1'b1;
        cyc(1'b1, 1'b0, 12'h0, 1'b0);
        run(NS, 12'h246);
        idle(1);
        chk("t6_avg", {16'd0, bus.avg_out}, 32'h2460);

        idle(4);
        chk("sb_empty", sbq.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
